// File: rtl/nuc_stream_writer.sv
// nuc_stream_writer: unpacks a byte stream into the 2-bit nucleotide memory.
// Optional running checksum output when NUC_WR_CHECKSUM_EN is defined.
module nuc_stream_writer #(
    parameter int W  = 65536,
    parameter int AW = $clog2(W)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_wdata,
    output logic          busy,
    output logic          done,
`ifdef NUC_WR_CHECKSUM_EN
    output logic [AW:0]   count,
    output logic [7:0]    checksum
`else
    output logic [AW:0]   count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        DONE
    } state_t;

    localparam logic [AW:0] WMAX = (AW+1)'(W);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t      state;
    state_t      state_nx;
    logic [AW:0] lenq;
    logic [AW:0] len_clip;
    logic [AW:0] count_inc;
    logic [7:0]  shreg;
    logic [1:0]  phase;
    logic        last_nuc;
    logic        phase_end;

    // A load never asks for more than the memory holds.
    assign len_clip  = (len > WMAX) ? WMAX : len;
    assign count_inc = count + ONE;
    assign last_nuc  = (count_inc == lenq);
    assign phase_end = (phase == 2'd3);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and state-decoded outputs; reset forces every output quiet.
    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 2'b00;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len_clip == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = count[AW-1:0];
                mem_wdata = shreg[7:6];
                if (last_nuc) begin
                    state_nx = DONE;
                end else if (phase_end) begin
                    state_nx = FETCH;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (reset) begin
            byte_ready = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = 2'b00;
            busy       = 1'b0;
            done       = 1'b0;
        end
    end

    // Length latch, shift register, write counter and nucleotide phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            lenq  <= '0;
            count <= '0;
            shreg <= 8'h00;
            phase <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lenq  <= len_clip;
                        count <= '0;
                    end
                end
                FETCH: begin
                    if (byte_valid) begin
                        shreg <= byte_in;
                        phase <= 2'd0;
                    end
                end
                WRITE: begin
                    shreg <= {shreg[5:0], 2'b00};
                    count <= count_inc;
                    phase <= phase + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef NUC_WR_CHECKSUM_EN
    // Running mod-256 sum of every nucleotide written in the current load.
    always_ff @(posedge clock) begin
        if (reset) begin
            checksum <= 8'h00;
        end else if (state == IDLE && start) begin
            checksum <= 8'h00;
        end else if (state == WRITE) begin
            checksum <= checksum + {6'b0, shreg[7:6]};
        end
    end
`endif

endmodule

// File: tb/tb_nuc_stream_writer.sv
// tb_nuc_stream_writer: directed and random loads against a nucleotide-list model.
// Checksum checks are compiled in when NUC_WR_CHECKSUM_EN is defined.
module tb_nuc_stream_writer;

    localparam int W  = 65536;
    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   len;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
`ifdef NUC_WR_CHECKSUM_EN
    logic [7:0]    checksum;
    int            sum_model;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nwr      = 0;

    logic [AW-1:0] exp_a[$];
    logic [1:0]    exp_d[$];
    logic [7:0]    byte_q[$];

    bit s_acc;
    bit s_done;
    bit s_ready;
    bit s_we;
    bit s_busy;

    nuc_stream_writer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
`ifdef NUC_WR_CHECKSUM_EN
        .count      (count),
        .checksum   (checksum)
`else
        .count      (count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sampled on the falling edge; every write is matched in order.
    task automatic sample();
        cyc++;
        s_acc   = (byte_ready === 1'b1) && (byte_valid === 1'b1);
        s_done  = (done === 1'b1);
        s_ready = (byte_ready === 1'b1);
        s_we    = (mem_we !== 1'b0);
        s_busy  = (busy === 1'b1);
        if (mem_we === 1'b1) begin
            nwr++;
            if (exp_a.size() == 0) begin
                chk("extra_write", 32'(mem_we), 32'd0);
            end else begin
                chk("wr_addr", 32'(mem_addr), 32'(exp_a.pop_front()));
                chk("wr_data", 32'(mem_wdata), 32'(exp_d.pop_front()));
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_bytes(input int n);
        byte_q.delete();
        for (int i = 0; i < (n + 3) / 4; i++) begin
            byte_q.push_back(8'($urandom));
        end
    endtask

    // Expected writes: nucleotide i is bit pair (3 - i%4) of byte i/4.
    task automatic build_model(input int lenq);
        exp_a.delete();
        exp_d.delete();
`ifdef NUC_WR_CHECKSUM_EN
        sum_model = 0;
`endif
        for (int i = 0; i < lenq; i++) begin
            logic [7:0] b;
            logic [1:0] d;
            b = byte_q[i / 4];
            d = b[(7 - 2 * (i % 4)) -: 2];
            exp_a.push_back(AW'(i));
            exp_d.push_back(d);
`ifdef NUC_WR_CHECKSUM_EN
            sum_model = (sum_model + int'(d)) % 256;
`endif
        end
    endtask

    task automatic run_load(input int n, input int gapmax,
                            input int first_gap, input bit held,
                            input bit poke);
        int lenq;
        int nb;
        int lastw;
        int c_start;
        int c_acc;
        int c_done;
        int gap;
        int bi;
        int w0;
        bit saw_ready;
        bit got_acc;
        bit got_done;
        lenq = (n > W) ? W : n;
        build_model(lenq);
        nb        = (lenq + 3) / 4;
        lastw     = lenq - 4 * (nb - 1);
        w0        = nwr;
        bi        = 0;
        gap       = first_gap;
        saw_ready = 0;
        got_acc   = 0;
        got_done  = 0;
        c_acc     = 0;
        c_done    = 0;
        len        = (AW+1)'(n);
        start      = 1'b1;
        byte_valid = 1'b0;
        tick();
        c_start = cyc;
        for (int k = 0; k < 4000 && !got_done; k++) begin
            if (poke && k == 3) begin
                start = 1'b1;
                len   = (AW+1)'(1);
            end else begin
                start = 1'b0;
            end
            if (gap > 0) begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_in    = (bi < byte_q.size()) ? byte_q[bi] : 8'($urandom);
            end
            tick();
            if (s_ready) saw_ready = 1;
            if (s_done) begin
                got_done = 1;
                c_done   = cyc;
                chk("count_at_done", 32'(count), 32'(lenq));
                chk("busy_at_done", 32'(s_busy), 32'd0);
            end else if (lenq > 0) begin
                chk("busy_in_load", 32'(s_busy), 32'd1);
            end
            if (s_acc) begin
                if (!got_acc) c_acc = cyc;
                got_acc = 1;
                bi++;
                gap = $urandom_range(0, gapmax);
            end else if (gap > 0) begin
                gap--;
            end
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        chk("done_seen", 32'(got_done), 32'd1);
        chk("queue_drained", 32'(exp_a.size()), 32'd0);
        chk("write_count", 32'(nwr - w0), 32'(lenq));
        if (lenq == 0) begin
            chk("len0_latency", 32'(c_done - c_start), 32'd1);
            chk("len0_no_ready", 32'(saw_ready), 32'd0);
        end else if (held) begin
            chk("done_latency", 32'(c_done - c_acc),
                32'((nb - 1) * 5 + lastw + 1));
        end
        tick();
        chk("done_pulse", 32'(s_done), 32'd0);
        chk("idle_busy", 32'(s_busy), 32'd0);
        chk("count_hold", 32'(count), 32'(lenq));
`ifdef NUC_WR_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(sum_model));
`endif
    endtask

    initial begin
        int w0;
        reset      = 1'b1;
        start      = 1'b0;
        len        = '0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        reset = 1'b0;
        tick();

        byte_q = '{8'h1B, 8'hE4};
        run_load(8, 0, 0, 1, 0);

        byte_q = '{8'hFF, 8'h40};
        run_load(5, 0, 0, 1, 1);

        byte_q.delete();
        run_load(0, 0, 0, 0, 0);

        byte_q = '{8'hC0};
        run_load(4, 0, 7, 1, 0);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 40);
            fill_bytes(n);
            run_load(n, 3, $urandom_range(0, 3), 0, (t % 2) == 0);
        end

        fill_bytes(13);
        run_load(13, 0, 0, 1, 0);

        byte_q = '{8'hFF, 8'hFF};
        run_load(8, 0, 0, 1, 0);
`ifdef NUC_WR_CHECKSUM_EN
        chk("checksum_24", 32'(checksum), 32'd24);
`endif

        byte_q = '{8'h1B};
        build_model(1);
        w0         = nwr;
        len        = (AW+1)'(8);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h1B;
        tick();
        byte_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("we_in_reset", 32'(s_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_ready", 32'(byte_ready), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("abort_writes", 32'(nwr - w0), 32'd1);
        chk("abort_drained", 32'(exp_a.size()), 32'd0);
        chk("abort_we_after", 32'(mem_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
